// File: rtl/full_adder_s_pkg.sv
// Shared types for the full adder cell.
// Bundles the sum/carry pair held in the output register.
package full_adder_s_pkg;

  typedef struct packed {
    logic cout;
    logic s;
  } fa_out_t;

endpackage

// File: rtl/full_adder_s_half_adder.sv
// Half adder: propagate and generate for one bit pair.
// Instantiated twice by full_adder_s.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder_s.sv
// Single-bit full adder from two half adders and an OR.
// Also provides a registered copy of sum and carry.
module full_adder_s
  import full_adder_s_pkg::*;
(
  output logic S,
  output logic Cout,
  input  logic Cin,
  input  logic A,
  input  logic B,
  input  logic clk,
  input  logic rst_n,
  output logic S_q,
  output logic Cout_q
);

  logic    p;
  logic    g1;
  logic    g2;
  fa_out_t q;

  half_adder ha0 (
    .a (A),
    .b (B),
    .s (p),
    .c (g1)
  );

  half_adder ha1 (
    .a (p),
    .b (Cin),
    .s (S),
    .c (g2)
  );

  assign Cout = g1 | g2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q.s    <= S;
      q.cout <= Cout;
    end
  end

  assign S_q    = q.s;
  assign Cout_q = q.cout;

endmodule

// File: tb/tb_full_adder_s.sv
// Self-checking bench for full_adder_s.
// Reference model: {Cout,S} = A + B + Cin.
module tb_full_adder_s;

  logic clk;
  logic rst_n;
  logic A;
  logic B;
  logic Cin;
  logic S;
  logic Cout;
  logic S_q;
  logic Cout_q;

  int checks;
  int errors;

  logic [2:0] tt_in [8] = '{3'b000, 3'b010, 3'b100, 3'b110,
                            3'b001, 3'b011, 3'b101, 3'b111};
  logic       tt_s  [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
  logic       tt_c  [8] = '{0, 0, 0, 1, 0, 1, 1, 1};

  full_adder_s dut (
    .S      (S),
    .Cout   (Cout),
    .Cin    (Cin),
    .A      (A),
    .B      (B),
    .clk    (clk),
    .rst_n  (rst_n),
    .S_q    (S_q),
    .Cout_q (Cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #90000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] model(input logic a, input logic b,
                                       input logic c);
    int sum;
    sum = int'(a) + int'(b) + int'(c);
    return 2'(sum);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    A = 1'b0; B = 1'b0; Cin = 1'b0;
    #1;
    checks++;
    if ({Cout_q, S_q} !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got %b, required 00", {Cout_q, S_q});
    end
  endtask

  task automatic test_truth_table();
    for (int i = 0; i < 8; i++) begin
      {A, B, Cin} = tt_in[i];
      #1;
      checks++;
      if ({S, Cout} !== {tt_s[i], tt_c[i]}) begin
        errors++;
        $display("FAIL truth_table %b: got S/Cout %b%b, required %b%b",
                 tt_in[i], S, Cout, tt_s[i], tt_c[i]);
      end
      checks++;
      if ({Cout, S} !== model(A, B, Cin)) begin
        errors++;
        $display("FAIL arith %b: got %b, required %b",
                 tt_in[i], {Cout, S}, model(A, B, Cin));
      end
      #1;
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_q;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      A   = 1'($urandom_range(0, 1));
      B   = 1'($urandom_range(0, 1));
      Cin = 1'($urandom_range(0, 1));
      #1;
      exp_q = model(A, B, Cin);
      checks++;
      if ({Cout, S} !== exp_q) begin
        errors++;
        $display("FAIL random_comb %b%b%b: got %b, required %b",
                 A, B, Cin, {Cout, S}, exp_q);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({Cout_q, S_q} !== exp_q) begin
        errors++;
        $display("FAIL random_reg %0d: got %b, required %b",
                 i, {Cout_q, S_q}, exp_q);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    rst_n = 1'b1;
    A = 1'b0; B = 1'b0; Cin = 1'b0;
    @(negedge clk);
    A = 1'b1; B = 1'b1; Cin = 1'b0;
    #1;
    checks++;
    if ({Cout, Cout_q} !== 2'b10) begin
      errors++;
      $display("FAIL latency_pre: got Cout/Cout_q %b%b, required 10",
               Cout, Cout_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({Cout_q, S_q} !== 2'b10) begin
      errors++;
      $display("FAIL latency_post: got %b, required 10", {Cout_q, S_q});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    A = 1'b1; B = 1'b1; Cin = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({Cout_q, S_q} !== 2'b11) begin
      errors++;
      $display("FAIL mid_load: got %b, required 11", {Cout_q, S_q});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({Cout_q, S_q} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_q: got %b, required 00", {Cout_q, S_q});
    end
    checks++;
    if ({Cout, S} !== 2'b11) begin
      errors++;
      $display("FAIL mid_reset_comb: got %b, required 11", {Cout, S});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({Cout_q, S_q} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_hold: got %b, required 00", {Cout_q, S_q});
    end
  endtask

  task automatic test_reset_release();
    A = 1'b0; B = 1'b1; Cin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({Cout_q, S_q} !== 2'b00) begin
      errors++;
      $display("FAIL release_pre: got %b, required 00", {Cout_q, S_q});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({Cout_q, S_q} !== 2'b01) begin
      errors++;
      $display("FAIL release_post: got %b, required 01", {Cout_q, S_q});
    end
  endtask

  task automatic test_simultaneous();
    @(posedge clk);
    A <= 1'b1;
    #1;
    checks++;
    if ({S_q, S, Cout} !== 3'b101) begin
      errors++;
      $display("FAIL simul_edge: got S_q/S/Cout %b, required 101",
               {S_q, S, Cout});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({Cout_q, S_q} !== 2'b10) begin
      errors++;
      $display("FAIL simul_next: got %b, required 10", {Cout_q, S_q});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_truth_table();
    test_random();
    test_latency();
    test_reset_mid();
    test_reset_release();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
